// File: rtl/pushbutton_processor.sv
// Scoreboard pushbutton front end: 2-FF synchronizer, debouncer, and a press
// classifier emitting a one-cycle count_up (short press) or count_down (long press).
module pushbutton_processor #(
  parameter int unsigned DEBOUNCE_MS   = 20,
  parameter int unsigned LONG_PRESS_MS = 2000,
  parameter int unsigned CNT_W         = 12
) (
  input  logic clk_1khz,
  input  logic rst_i,
  input  logic pushbutton_i,
  output logic count_up,
  output logic count_down
);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_MS - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_PRESS_MS - 1);
  localparam logic [CNT_W-1:0] HOLD_SAT  = CNT_W'(LONG_PRESS_MS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESSED,
    S_LONG_HELD
  } state_t;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_btn_db;
  logic [CNT_W-1:0] r_deb_cnt;
  logic [CNT_W-1:0] r_low_cnt;
  logic             r_armed;
  logic [CNT_W-1:0] r_hold_cnt;
  logic             r_count_up;
  logic             r_count_down;
  state_t           r_state;

  logic             w_btn_s;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_hold_nxt;
  logic             w_up_nxt;
  logic             w_dn_nxt;

  assign w_btn_s    = r_sync2;
  assign count_up   = r_count_up;
  assign count_down = r_count_down;

  // r_armed blocks new presses after reset until the button has been seen
  // released for a full debounce window, so a press interrupted by reset
  // cannot resurface as a fresh press once the debouncer re-accepts the level.
  always_ff @(posedge clk_1khz) begin
    if (!rst_i) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_btn_db  <= 1'b0;
      r_deb_cnt <= '0;
      r_low_cnt <= '0;
      r_armed   <= 1'b0;
    end else begin
      r_sync1 <= pushbutton_i;
      r_sync2 <= r_sync1;

      if (w_btn_s != r_btn_db) begin
        if (r_deb_cnt == DB_LAST) begin
          r_btn_db  <= w_btn_s;
          r_deb_cnt <= '0;
        end else begin
          r_deb_cnt <= r_deb_cnt + 1'b1;
        end
      end else begin
        r_deb_cnt <= '0;
      end

      if (!r_armed) begin
        if (w_btn_s) begin
          r_low_cnt <= '0;
        end else if (r_low_cnt == DB_LAST) begin
          r_armed <= 1'b1;
        end else begin
          r_low_cnt <= r_low_cnt + 1'b1;
        end
      end
    end
  end

  // Release is tested before the hold threshold so a coincident fall yields count_up.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    w_up_nxt    = 1'b0;
    w_dn_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_armed && r_btn_db) begin
          w_state_nxt = S_PRESSED;
          w_hold_nxt  = '0;
        end
      end
      S_PRESSED: begin
        if (!r_btn_db) begin
          w_up_nxt    = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_hold_cnt >= HOLD_LAST) begin
          w_dn_nxt    = 1'b1;
          w_state_nxt = S_LONG_HELD;
        end else begin
          w_hold_nxt = r_hold_cnt + 1'b1;
        end
      end
      S_LONG_HELD: begin
        if (r_hold_cnt < HOLD_SAT) begin
          w_hold_nxt = r_hold_cnt + 1'b1;
        end
        if (!r_btn_db) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_1khz) begin
    if (!rst_i) begin
      r_state      <= S_IDLE;
      r_hold_cnt   <= '0;
      r_count_up   <= 1'b0;
      r_count_down <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_hold_cnt   <= w_hold_nxt;
      r_count_up   <= w_up_nxt;
      r_count_down <= w_dn_nxt;
    end
  end

endmodule

// File: tb/tb_pushbutton_processor.sv
// Directed bench for pushbutton_processor: reset, bounce, glitch, long press,
// threshold boundary and reset-abort scenarios with hand-computed pulse cycles.
module tb_pushbutton_processor;

  logic clk_1khz = 1'b0;
  logic rst_i = 1'b0;
  logic pushbutton_i = 1'b0;
  logic count_up;
  logic count_down;

  int n_tests = 0;
  int n_fail = 0;

  int cyc = 0;
  int n_up = 0;
  int n_dn = 0;
  int n_bad = 0;
  int last_up = -1;
  int last_dn = -1;
  bit db_hi = 1'b0;
  bit prev_up = 1'b0;
  bit prev_dn = 1'b0;

  pushbutton_processor #(
    .DEBOUNCE_MS  (20),
    .LONG_PRESS_MS(2000),
    .CNT_W        (12)
  ) dut (
    .clk_1khz    (clk_1khz),
    .rst_i       (rst_i),
    .pushbutton_i(pushbutton_i),
    .count_up    (count_up),
    .count_down  (count_down)
  );

  always #5 clk_1khz = ~clk_1khz;

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation time exceeded, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // cyc = number of rising edges so far; outputs sampled 1 time unit after each edge
  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk_1khz);
      #1;
      cyc++;
      if (count_up === 1'b1) begin
        n_up++;
        last_up = cyc;
        if (prev_up) n_bad++;
      end else if (count_up !== 1'b0) begin
        n_bad++;
      end
      if (count_down === 1'b1) begin
        n_dn++;
        last_dn = cyc;
        if (prev_dn) n_bad++;
      end else if (count_down !== 1'b0) begin
        n_bad++;
      end
      if (count_up === 1'b1 && count_down === 1'b1) n_bad++;
      if (dut.r_btn_db === 1'b1) db_hi = 1'b1;
      prev_up = (count_up === 1'b1);
      prev_dn = (count_down === 1'b1);
    end
  endtask

  task automatic clear_stats();
    n_up = 0;
    n_dn = 0;
    n_bad = 0;
    last_up = -1;
    last_dn = -1;
    db_hi = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pushbutton_i = ~pushbutton_i;
      run(1);
      n_tests++;
      if (count_up !== 1'b0 || count_down !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_outputs: got up=%b dn=%b expected up=0 dn=0", count_up, count_down);
      end
    end
    n_tests++;
    if (dut.r_btn_db !== 1'b0 || dut.r_hold_cnt !== 12'd0 || dut.r_deb_cnt !== 12'd0) begin
      n_fail++;
      $display("FAIL reset_state: got db=%b hold=%0d deb=%0d expected 0 0 0",
               dut.r_btn_db, dut.r_hold_cnt, dut.r_deb_cnt);
    end
    pushbutton_i = 1'b0;
    rst_i = 1'b1;
    run(40);
  endtask

  task automatic test_bouncy_short();
    int rel;
    clear_stats();
    pushbutton_i = 1'b1; run(1);
    pushbutton_i = 1'b0; run(2);
    pushbutton_i = 1'b1; run(2);
    pushbutton_i = 1'b0; run(1);
    pushbutton_i = 1'b1; run(2);
    run(30);
    n_tests++;
    if (n_up != 0 || n_dn != 0) begin
      n_fail++;
      $display("FAIL bouncy_no_early_pulse: got up=%0d dn=%0d expected 0 0", n_up, n_dn);
    end
    pushbutton_i = 1'b0;
    rel = cyc;
    run(40);
    n_tests++;
    if (n_up != 1 || last_up != rel + 23) begin
      n_fail++;
      $display("FAIL bouncy_count_up: got n=%0d at=%0d expected n=1 at=%0d", n_up, last_up, rel + 23);
    end
    n_tests++;
    if (n_dn != 0 || n_bad != 0) begin
      n_fail++;
      $display("FAIL bouncy_no_down: got dn=%0d bad=%0d expected 0 0", n_dn, n_bad);
    end
  endtask

  task automatic test_glitch();
    clear_stats();
    pushbutton_i = 1'b1; run(10);
    pushbutton_i = 1'b0; run(40);
    n_tests++;
    if (db_hi || n_up != 0 || n_dn != 0) begin
      n_fail++;
      $display("FAIL glitch_reject: got db_hi=%b up=%0d dn=%0d expected 0 0 0", db_hi, n_up, n_dn);
    end
  endtask

  task automatic test_long_press();
    int p;
    clear_stats();
    pushbutton_i = 1'b1;
    p = cyc;
    run(2130);
    n_tests++;
    if (n_dn != 1 || last_dn != p + 2023) begin
      n_fail++;
      $display("FAIL long_count_down: got n=%0d at=%0d expected n=1 at=%0d", n_dn, last_dn, p + 2023);
    end
    pushbutton_i = 1'b0; run(2);
    pushbutton_i = 1'b1; run(2);
    pushbutton_i = 1'b0; run(1);
    pushbutton_i = 1'b1; run(2);
    pushbutton_i = 1'b0; run(60);
    n_tests++;
    if (n_up != 0 || n_dn != 1 || n_bad != 0) begin
      n_fail++;
      $display("FAIL long_release: got up=%0d dn=%0d bad=%0d expected 0 1 0", n_up, n_dn, n_bad);
    end
  endtask

  task automatic test_boundary();
    int p;
    clear_stats();
    pushbutton_i = 1'b1;
    p = cyc;
    run(2000);
    pushbutton_i = 1'b0;
    run(40);
    n_tests++;
    if (n_up != 1 || last_up != p + 2023 || n_dn != 0) begin
      n_fail++;
      $display("FAIL boundary_under: got up=%0d at=%0d dn=%0d expected up=1 at=%0d dn=0",
               n_up, last_up, n_dn, p + 2023);
    end
    clear_stats();
    pushbutton_i = 1'b1;
    p = cyc;
    run(2001);
    pushbutton_i = 1'b0;
    run(40);
    n_tests++;
    if (n_dn != 1 || last_dn != p + 2023 || n_up != 0) begin
      n_fail++;
      $display("FAIL boundary_over: got dn=%0d at=%0d up=%0d expected dn=1 at=%0d up=0",
               n_dn, last_dn, n_up, p + 2023);
    end
  endtask

  task automatic test_reset_midpress();
    int rel;
    clear_stats();
    pushbutton_i = 1'b1;
    run(1000);
    rst_i = 1'b0; run(3);
    rst_i = 1'b1; run(500);
    pushbutton_i = 1'b0;
    run(60);
    n_tests++;
    if (n_up != 0 || n_dn != 0) begin
      n_fail++;
      $display("FAIL reset_midpress: got up=%0d dn=%0d expected 0 0", n_up, n_dn);
    end
    clear_stats();
    pushbutton_i = 1'b1; run(50);
    pushbutton_i = 1'b0;
    rel = cyc;
    run(40);
    n_tests++;
    if (n_up != 1 || last_up != rel + 23 || n_dn != 0) begin
      n_fail++;
      $display("FAIL press_after_abort: got up=%0d at=%0d dn=%0d expected up=1 at=%0d dn=0",
               n_up, last_up, n_dn, rel + 23);
    end
  endtask

  task automatic test_back_to_back();
    int rel1;
    int rel2;
    clear_stats();
    pushbutton_i = 1'b1; run(40);
    pushbutton_i = 1'b0; rel1 = cyc; run(30);
    n_tests++;
    if (n_up != 1 || last_up != rel1 + 23) begin
      n_fail++;
      $display("FAIL b2b_first: got up=%0d at=%0d expected up=1 at=%0d", n_up, last_up, rel1 + 23);
    end
    pushbutton_i = 1'b1; run(40);
    pushbutton_i = 1'b0; rel2 = cyc; run(40);
    n_tests++;
    if (n_up != 2 || last_up != rel2 + 23 || n_dn != 0 || n_bad != 0) begin
      n_fail++;
      $display("FAIL b2b_second: got up=%0d at=%0d dn=%0d bad=%0d expected up=2 at=%0d dn=0 bad=0",
               n_up, last_up, n_dn, n_bad, rel2 + 23);
    end
  endtask

  initial begin
    test_reset();
    test_bouncy_short();
    test_glitch();
    test_long_press();
    test_boundary();
    test_reset_midpress();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
